// File: rtl/exp7_pkg.sv
// Shared definitions for the sequence playback block: state codes
// (also used by the display decoder) and default lit/dark durations.
package exp7_pkg;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    LE        = 4'd1,
    ACENDE    = 4'd2,
    APAGA     = 4'd3,
    PROXIMO   = 4'd4,
    TERMINADO = 4'd5
  } estado_t;

  localparam int ON_CYCLES_DEFAULT  = 1000;
  localparam int OFF_CYCLES_DEFAULT = 500;

  // Timer width able to hold the larger of the two terminal counts; never
  // narrower than one bit so a 1-cycle on/off time still elaborates.
  function automatic int largura_timer(input int on_c, input int off_c);
    int maior;
    int largura;
    maior   = (on_c > off_c) ? on_c : off_c;
    largura = $clog2(maior);
    return (largura < 1) ? 1 : largura;
  endfunction

endpackage

// File: rtl/exp7_contador_tempo.sv
// Up-counter used to time how long each item stays lit or dark.
// fim_contagem flags the cycle in which the count equals valor_final.
module exp7_contador_tempo #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] valor_final,
  output logic             fim_contagem
);

  logic [WIDTH-1:0] contagem;

  // Count while enabled; clear has priority so the owner can restart it at terminal count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (clear) begin
      contagem <= '0;
    end else if (enable) begin
      contagem <= contagem + WIDTH'(1);
    end
  end

  assign fim_contagem = (contagem == valor_final);

endmodule

// File: rtl/exp7_mostra_sequencia.sv
// Playback sequencer for the memory game: walks memory from address 0 up to
// a latched limit, lighting each colour for ON_CYCLES and blanking it for
// OFF_CYCLES, then pulses fim once the last item has gone dark.
module exp7_mostra_sequencia
  import exp7_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int ON_CYCLES  = ON_CYCLES_DEFAULT,
  parameter int OFF_CYCLES = OFF_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              fim,
  output logic [3:0]        db_estado
);

  localparam int TIMER_W = largura_timer(ON_CYCLES, OFF_CYCLES);
  localparam logic [TIMER_W-1:0] ULTIMO_ACESO    = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ULTIMO_APAGADO  = TIMER_W'(OFF_CYCLES - 1);

  estado_t              estado;
  logic [ADDR_W-1:0]    limite_reg;
  logic                 timer_clear;
  logic                 timer_enable;
  logic                 timer_fim;
  logic [TIMER_W-1:0]   timer_final;

  // The single timer runs only while lit or dark and restarts at each terminal count,
  // so leaving either timed state always hands the next one a zeroed timer.
  always_comb begin
    timer_enable = (estado == ACENDE) || (estado == APAGA);
    timer_clear  = abortar || timer_fim || !timer_enable;
    timer_final  = (estado == ACENDE) ? ULTIMO_ACESO : ULTIMO_APAGADO;
  end

  exp7_contador_tempo #(
    .WIDTH(TIMER_W)
  ) u_contador_tempo (
    .clock       (clock),
    .reset       (reset),
    .clear       (timer_clear),
    .enable      (timer_enable),
    .valor_final (timer_final),
    .fim_contagem(timer_fim)
  );

  // Playback FSM; every output is registered and abortar overrides all states.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= OCIOSO;
      endereco   <= '0;
      leds       <= '0;
      ocupado    <= 1'b0;
      fim        <= 1'b0;
      limite_reg <= '0;
    end else if (abortar) begin
      estado   <= OCIOSO;
      endereco <= '0;
      leds     <= '0;
      ocupado  <= 1'b0;
      fim      <= 1'b0;
    end else begin
      fim <= 1'b0;
      case (estado)
        OCIOSO: begin
          endereco <= '0;
          leds     <= '0;
          if (iniciar) begin
            limite_reg <= limite;
            ocupado    <= 1'b1;
            estado     <= LE;
          end
        end
        LE: begin
          leds   <= dado_mem;
          estado <= ACENDE;
        end
        ACENDE: begin
          if (timer_fim) begin
            leds   <= '0;
            estado <= APAGA;
          end
        end
        APAGA: begin
          leds <= '0;
          if (timer_fim) begin
            if (endereco == limite_reg) begin
              fim    <= 1'b1;
              estado <= TERMINADO;
            end else begin
              estado <= PROXIMO;
            end
          end
        end
        PROXIMO: begin
          endereco <= endereco + ADDR_W'(1);
          estado   <= LE;
        end
        TERMINADO: begin
          endereco <= '0;
          ocupado  <= 1'b0;
          estado   <= OCIOSO;
        end
        default: begin
          endereco <= '0;
          leds     <= '0;
          ocupado  <= 1'b0;
          estado   <= OCIOSO;
        end
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp7_mostra_sequencia.sv
// Self-checking bench for exp7_mostra_sequencia: a schedule-based model
// derived from the playback timing is compared every cycle, plus literal
// checks on fim timing, lit values/durations and address steps.
module tb_exp7_mostra_sequencia;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int ON     = 4;
  localparam int OFF    = 2;
  localparam int PERIOD_ITEM = ON + OFF + 2;

  logic              clock   = 1'b0;
  logic              reset   = 1'b1;
  logic              iniciar = 1'b0;
  logic              abortar = 1'b0;
  logic [ADDR_W-1:0] limite  = '0;
  logic [DATA_W-1:0] dado_mem;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              fim;
  logic [3:0]        db_estado;

  logic [DATA_W-1:0] mem [16];

  int checks = 0;
  int passes = 0;

  bit m_active = 1'b0;
  int m_t      = 0;
  int m_L      = 0;

  int lit_vals[$];
  int lit_lens[$];
  int addr_seq[$];
  int last_lit_n;

  assign dado_mem = mem[endereco];

  exp7_mostra_sequencia #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .abortar  (abortar),
    .limite   (limite),
    .dado_mem (dado_mem),
    .endereco (endereco),
    .leds     (leds),
    .ocupado  (ocupado),
    .fim      (fim),
    .db_estado(db_estado)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Cycle index (1 = first cycle after accept) at which fim is high.
  function automatic int runEnd(input int L);
    return 1 + L * PERIOD_ITEM + ON + OFF + 1;
  endfunction

  // Expected {endereco, leds, ocupado, fim, db_estado} from the playback schedule.
  function automatic logic [13:0] modelOutputs();
    int i;
    int o;
    logic [3:0] e_addr;
    logic [3:0] e_leds;
    logic [3:0] e_db;
    logic       e_fim;
    if (!m_active) return '0;
    i      = (m_t - 1) / PERIOD_ITEM;
    o      = (m_t - 1) % PERIOD_ITEM;
    e_addr = 4'(i);
    e_leds = (o >= 1 && o <= ON) ? mem[i] : 4'd0;
    if (o == 0)              e_db = 4'd1;
    else if (o <= ON)        e_db = 4'd2;
    else if (o <= ON + OFF)  e_db = 4'd3;
    else if (i == m_L)       e_db = 4'd5;
    else                     e_db = 4'd4;
    e_fim = (o == PERIOD_ITEM - 1) && (i == m_L);
    return {e_addr, e_leds, 1'b1, e_fim, e_db};
  endfunction

  // Reference model: tracks whether a run is active and how far into it we are.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_L      <= 0;
    end else if (abortar) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (iniciar) begin
        m_active <= 1'b1;
        m_t      <= 1;
        m_L      <= int'(limite);
      end
    end else if (m_t == runEnd(m_L)) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clock) begin
    checkOutput("cycle_model", int'({endereco, leds, ocupado, fim, db_estado}), int'(modelOutputs()));
  end

  task automatic applyStimulus(input int L);
    limite  = 4'(L);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  // Follow a run from cycle 1, recording lit segments and addresses, until fim or budget.
  task automatic watchRun(input int budget, input int poke_n, output int fim_at);
    logic [3:0] prev_leds;
    lit_vals.delete();
    lit_lens.delete();
    addr_seq.delete();
    fim_at     = -1;
    prev_leds  = '0;
    last_lit_n = 0;
    for (int n = 1; n <= budget; n++) begin
      if (poke_n > 0 && n == poke_n) begin
        iniciar = 1'b1;
        limite  = 4'd9;
      end
      if (poke_n > 0 && n == poke_n + 1) begin
        iniciar = 1'b0;
        limite  = 4'd7;
      end
      if (leds != 0) begin
        if (prev_leds == 0) begin
          lit_vals.push_back(int'(leds));
          lit_lens.push_back(1);
        end else begin
          lit_lens[lit_lens.size()-1] = lit_lens[lit_lens.size()-1] + 1;
        end
        last_lit_n = n;
      end
      prev_leds = leds;
      if (addr_seq.size() == 0 || addr_seq[addr_seq.size()-1] != int'(endereco))
        addr_seq.push_back(int'(endereco));
      if (fim) begin
        fim_at = n;
        break;
      end
      @(negedge clock);
    end
  endtask

  // Directed scenarios followed by a randomized soak.
  initial begin
    int fim_at;
    int fim_seen;
    int exp_lit[4];
    exp_lit = '{1, 2, 4, 8};

    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("reset_idle", int'({endereco, leds, ocupado, fim, db_estado}), 0);

    // Single item
    applyStimulus(0);
    watchRun(60, 0, fim_at);
    checkOutput("fim_cycle_L0", fim_at, 8);
    checkOutput("lit_count_L0", lit_vals.size(), 1);
    checkOutput("lit_val_L0", (lit_vals.size() > 0) ? lit_vals[0] : -1, 1);
    checkOutput("lit_len_L0", (lit_lens.size() > 0) ? lit_lens[0] : -1, 4);
    checkOutput("dark_cycles_L0", fim_at - last_lit_n - 1, 2);
    @(negedge clock);
    checkOutput("ocupado_after_fim", int'(ocupado), 0);

    // Four items
    repeat (2) @(negedge clock);
    applyStimulus(3);
    watchRun(100, 0, fim_at);
    checkOutput("fim_cycle_L3", fim_at, 32);
    checkOutput("lit_count_L3", lit_vals.size(), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("lit_val_L3_%0d", k), (k < lit_vals.size()) ? lit_vals[k] : -1, exp_lit[k]);
      checkOutput($sformatf("lit_len_L3_%0d", k), (k < lit_lens.size()) ? lit_lens[k] : -1, 4);
      checkOutput($sformatf("addr_L3_%0d", k), (k < addr_seq.size()) ? addr_seq[k] : -1, k);
    end
    checkOutput("addr_steps_L3", addr_seq.size(), 4);

    // Abort during second lit item
    repeat (2) @(negedge clock);
    applyStimulus(3);
    repeat (10) @(negedge clock);
    checkOutput("abort_pre_state", int'(db_estado), 2);
    abortar = 1'b1;
    @(negedge clock);
    abortar = 1'b0;
    checkOutput("abort_state", int'(db_estado), 0);
    checkOutput("abort_leds", int'(leds), 0);
    checkOutput("abort_addr", int'(endereco), 0);
    checkOutput("abort_ocupado", int'(ocupado), 0);
    fim_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (fim) fim_seen++;
    end
    checkOutput("no_fim_after_abort", fim_seen, 0);

    // Busy iniciar and limite change ignored; back-to-back start
    applyStimulus(2);
    watchRun(100, 5, fim_at);
    checkOutput("fim_cycle_busy_L2", fim_at, 24);
    @(negedge clock);
    checkOutput("first_idle_after_fim", int'(db_estado), 0);
    applyStimulus(1);
    watchRun(100, 0, fim_at);
    checkOutput("fim_cycle_b2b_L1", fim_at, 16);
    checkOutput("lit_count_b2b", lit_vals.size(), 2);

    // Async reset mid-dark phase of item 1
    repeat (2) @(negedge clock);
    applyStimulus(2);
    repeat (13) @(negedge clock);
    checkOutput("pre_reset_state", int'(db_estado), 3);
    checkOutput("pre_reset_addr", int'(endereco), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_state", int'(db_estado), 0);
    checkOutput("async_reset_addr", int'(endereco), 0);
    checkOutput("async_reset_ocupado", int'(ocupado), 0);
    checkOutput("async_reset_leds", int'(leds), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // iniciar with abortar in idle stays idle
    iniciar = 1'b1;
    abortar = 1'b1;
    limite  = 4'd2;
    repeat (3) @(negedge clock);
    checkOutput("start_with_abort_state", int'(db_estado), 0);
    checkOutput("start_with_abort_ocupado", int'(ocupado), 0);
    iniciar = 1'b0;
    abortar = 1'b0;

    // Randomized soak with random memory contents
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(1, 15));
    repeat (3000) begin
      @(negedge clock);
      iniciar = ($urandom_range(0, 7) == 0);
      abortar = ($urandom_range(0, 299) == 0);
      limite  = 4'($urandom_range(0, 15));
    end
    iniciar = 1'b0;
    abortar = 1'b0;
    repeat (5) @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
